scheduler_request_responder: RTL and testbench
==============================================

Name: scheduler_request_responder

Overview:
- Memory-side consumer of the scheduler request buffer: samples the head request (REN/WEN, address, store data), performs one RAM access under a ready handshake, then pulses request_done so the buffer retires the entry.
- Returns load data with the serviced address and flags stalled accesses through a timeout error.
- Sits between scheduler_buffer and the RAM/bus model, one outstanding request at a time.

Parameters:
- WORD_W, 32, data and address width.
- TIMEOUT, 255, maximum cycles in ACCESS waiting for mem_ready before abort; counter width $clog2(TIMEOUT+1).
- CNT_W, 16, width of the serviced-request counter.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- ramREN_curr  in  1  head entry is a read.
- ramWEN_curr  in  1  head entry is a write.
- ramaddr_rq  in  WORD_W  head entry address.
- ramstore_rq  in  WORD_W  head entry store data.
- request_done  out  1  one-cycle pulse; retires head entry.
- load_valid  out  1  one-cycle pulse with request_done for a successful read.
- load_data  out  WORD_W  read data, valid while load_valid.
- resp_addr  out  WORD_W  address of the retired request, valid with request_done (memaddr callback).
- resp_err  out  1  one-cycle pulse with request_done when the access timed out or was illegal.
- mem_ren  out  1  RAM read strobe.
- mem_wen  out  1  RAM write strobe.
- mem_addr  out  WORD_W  RAM address.
- mem_wdata  out  WORD_W  RAM write data.
- mem_rdata  in  WORD_W  RAM read data, sampled on mem_ready.
- mem_ready  in  1  RAM access complete, one cycle.
- busy  out  1  state != IDLE.
- done_count  out  CNT_W  number of request_done pulses since reset, wraps.

Behaviour:
- Reset: state IDLE; all outputs 0; latched op/addr/data/rdata, timeout counter and done_count cleared. Reset mid-access drops mem_ren/mem_wen immediately; the in-flight request is not retired.
- FSM states: IDLE, ACCESS, DONE, GAP.
- IDLE: if exactly one of ramREN_curr/ramWEN_curr is 1, latch op, ramaddr_rq and ramstore_rq, clear the timeout counter, then go to ACCESS.
  - If both are 1, latch the address and go to DONE with an error flag set. No memory access is made.
  - If neither is 1, stay in IDLE.
- ACCESS: drive mem_ren or mem_wen from the latched op, plus mem_addr and mem_wdata from the latched registers. These are held stable until exit; the inputs are not re-sampled.
  - mem_ready=1: capture mem_rdata (reads only), go to DONE.
  - Otherwise increment the timeout counter. When it equals TIMEOUT with no mem_ready, set the error flag and go to DONE.
  - mem_ready in the same cycle the counter reaches TIMEOUT counts as success.
  - Strobes are 0 outside ACCESS.
- DONE, exactly one cycle:
  - request_done=1 and resp_addr=latched address.
  - load_valid=1 and load_data=captured data if op is read and there is no error.
  - resp_err=error flag.
  - done_count increments, wrapping at 2^CNT_W.
  - Then go to GAP.
- GAP: one dead cycle so the buffer read pointer and entry clear settle before the head is re-sampled. Then go to IDLE, clearing the error flag.
- Minimum latency from request visible in IDLE to request_done: 3 cycles with mem_ready in the first ACCESS cycle (IDLE→ACCESS→DONE). Throughput is at most one request per 4 cycles.
- mem_ready outside ACCESS is ignored.
- Write responses never assert load_valid. load_data holds its last value when not valid.

Decomposition:
- Shared package scheduler_pkg holds:
  - typedef enum logic [1:0] resp_state_t {IDLE, ACCESS, DONE, GAP};
  - typedef enum logic [1:0] req_op_t {OP_NONE=2'b00, OP_READ=2'b01, OP_WRITE=2'b10, OP_ILLEGAL=2'b11}, matching the buffer's tag encoding;
  - localparam WORD_W_DEFAULT=32.
- Timeout counter and done_count reuse socetlib_counter; no new sub-module is needed.

Test Plan:
- Read, immediate ready: REN=1, addr=0x0000_1000, mem_ready with mem_rdata=0xDEADBEEF in the first ACCESS cycle.
  → request_done, load_valid and load_data=0xDEADBEEF 2 cycles after latch; resp_addr=0x1000; done_count=1.
- Write, 5-cycle wait: WEN=1, addr=0x2000, store=0xCAFEF00D, mem_ready after 5 ACCESS cycles.
  → mem_wen high with mem_wdata=0xCAFEF00D for 6 cycles; request_done with load_valid=0 and resp_err=0.
- Timeout: REN=1, mem_ready never asserts, TIMEOUT=255.
  → mem_ren drops after 255 cycles; request_done and resp_err pulse together; load_valid=0.
- Illegal: REN=WEN=1, addr=0x3000.
  → no mem strobe; request_done and resp_err next cycle; resp_addr=0x3000.
- Back-to-back with scheduler_buffer: 3 queued requests (R 0x10, W 0x14, R 0x18), always-ready RAM.
  → three request_done pulses exactly 4 cycles apart; done_count=3; buffer empties.
- Reset mid-ACCESS: assert nRST=0 during a pending read.
  → mem_ren=0 asynchronously; no request_done; state IDLE; done_count=0 after release.

Source files
------------

// File: rtl/scheduler_pkg.sv
// Shared types for the scheduler request path: responder FSM states and the
// request op tag, encoded the same way as the buffer's entry tag.
package scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10,
    GAP    = 2'b11
  } resp_state_t;

  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_READ    = 2'b01,
    OP_WRITE   = 2'b10,
    OP_ILLEGAL = 2'b11
  } req_op_t;

  localparam int WORD_W_DEFAULT = 32;

endpackage

// File: rtl/scheduler_request_responder_if.sv
// RAM/bus side of the request responder: strobes, address and write data out,
// read data and a one-cycle ready back.
interface scheduler_request_responder_if #(
  parameter int WORD_W = scheduler_pkg::WORD_W_DEFAULT
);
  logic              mem_ren;
  logic              mem_wen;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_ren, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/socetlib_counter.sv
// Generic up-counter with synchronous clear; wraps to zero after reaching
// overflow_val.
module socetlib_counter #(
  parameter int N = 4
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         clear,
  input  logic         count_enable,
  input  logic [N-1:0] overflow_val,
  output logic [N-1:0] count_out
);

  logic [N-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_q == overflow_val) count_d = '0;
      else                         count_d = count_q + N'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_out = count_q;

endmodule

// File: rtl/scheduler_request_responder.sv
// Memory-side consumer of the scheduler request buffer: services the head
// entry with one RAM access, then pulses request_done to retire it.
module scheduler_request_responder
  import scheduler_pkg::*;
#(
  parameter int WORD_W  = WORD_W_DEFAULT,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          ramREN_curr,
  input  logic                          ramWEN_curr,
  input  logic [WORD_W-1:0]             ramaddr_rq,
  input  logic [WORD_W-1:0]             ramstore_rq,
  output logic                          request_done,
  output logic                          load_valid,
  output logic [WORD_W-1:0]             load_data,
  output logic [WORD_W-1:0]             resp_addr,
  output logic                          resp_err,
  scheduler_request_responder_if.master mem,
  output logic                          busy,
  output logic [CNT_W-1:0]              done_count
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  resp_state_t       state_q, state_d;
  req_op_t           op_q, op_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              mem_ren_q, mem_ren_d;
  logic              mem_wen_q, mem_wen_d;
  logic              request_done_q, request_done_d;
  logic              load_valid_q, load_valid_d;
  logic [WORD_W-1:0] load_data_q, load_data_d;
  logic [WORD_W-1:0] resp_addr_q, resp_addr_d;
  logic              resp_err_q, resp_err_d;

  logic              tmo_clear, tmo_en, done_en;
  logic [TMO_W-1:0]  tmo_cnt;

  socetlib_counter #(.N(TMO_W)) u_tmo_cnt (
    .CLK          (CLK),
    .nRST         (nRST),
    .clear        (tmo_clear),
    .count_enable (tmo_en),
    .overflow_val (TMO_MAX),
    .count_out    (tmo_cnt)
  );

  socetlib_counter #(.N(CNT_W)) u_done_cnt (
    .CLK          (CLK),
    .nRST         (nRST),
    .clear        (1'b0),
    .count_enable (done_en),
    .overflow_val ({CNT_W{1'b1}}),
    .count_out    (done_count)
  );

  // Response outputs are computed on the transition into DONE so that they
  // are registered and line up exactly with the DONE cycle.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    err_d          = err_q;
    mem_ren_d      = mem_ren_q;
    mem_wen_d      = mem_wen_q;
    request_done_d = 1'b0;
    load_valid_d   = 1'b0;
    load_data_d    = load_data_q;
    resp_addr_d    = resp_addr_q;
    resp_err_d     = 1'b0;
    tmo_clear      = 1'b0;
    tmo_en         = 1'b0;
    done_en        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ramREN_curr ^ ramWEN_curr) begin
          op_d      = ramREN_curr ? OP_READ : OP_WRITE;
          addr_d    = ramaddr_rq;
          wdata_d   = ramstore_rq;
          tmo_clear = 1'b1;
          mem_ren_d = ramREN_curr;
          mem_wen_d = ramWEN_curr;
          state_d   = ACCESS;
        end else if (ramREN_curr && ramWEN_curr) begin
          op_d           = OP_ILLEGAL;
          addr_d         = ramaddr_rq;
          err_d          = 1'b1;
          request_done_d = 1'b1;
          resp_addr_d    = ramaddr_rq;
          resp_err_d     = 1'b1;
          state_d        = DONE;
        end
      end
      ACCESS: begin
        if (mem.mem_ready) begin
          mem_ren_d      = 1'b0;
          mem_wen_d      = 1'b0;
          request_done_d = 1'b1;
          resp_addr_d    = addr_q;
          if (op_q == OP_READ) begin
            load_valid_d = 1'b1;
            load_data_d  = mem.mem_rdata;
          end
          state_d = DONE;
        end else begin
          tmo_en = 1'b1;
          // This increment brings the counter to TIMEOUT: abort the access.
          if (tmo_cnt == TMO_LAST) begin
            err_d          = 1'b1;
            mem_ren_d      = 1'b0;
            mem_wen_d      = 1'b0;
            request_done_d = 1'b1;
            resp_addr_d    = addr_q;
            resp_err_d     = 1'b1;
            state_d        = DONE;
          end
        end
      end
      DONE: begin
        done_en = 1'b1;
        state_d = GAP;
      end
      GAP: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q        <= IDLE;
      op_q           <= OP_NONE;
      addr_q         <= '0;
      wdata_q        <= '0;
      err_q          <= 1'b0;
      mem_ren_q      <= 1'b0;
      mem_wen_q      <= 1'b0;
      request_done_q <= 1'b0;
      load_valid_q   <= 1'b0;
      load_data_q    <= '0;
      resp_addr_q    <= '0;
      resp_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      err_q          <= err_d;
      mem_ren_q      <= mem_ren_d;
      mem_wen_q      <= mem_wen_d;
      request_done_q <= request_done_d;
      load_valid_q   <= load_valid_d;
      load_data_q    <= load_data_d;
      resp_addr_q    <= resp_addr_d;
      resp_err_q     <= resp_err_d;
    end
  end

  assign mem.mem_ren   = mem_ren_q;
  assign mem.mem_wen   = mem_wen_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign request_done = request_done_q;
  assign load_valid   = load_valid_q;
  assign load_data    = load_data_q;
  assign resp_addr    = resp_addr_q;
  assign resp_err     = resp_err_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_scheduler_request_responder.sv
// Directed bench for scheduler_request_responder: reads, writes, timeout,
// illegal requests, async reset and a back-to-back queue of three requests.
module tb_scheduler_request_responder;

  localparam int WORD_W  = 32;
  localparam int TIMEOUT = 255;
  localparam int CNT_W   = 16;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              ramREN_curr, ramWEN_curr;
  logic [WORD_W-1:0] ramaddr_rq, ramstore_rq;
  logic              request_done, load_valid, resp_err, busy;
  logic [WORD_W-1:0] load_data, resp_addr;
  logic [CNT_W-1:0]  done_count;

  int checks = 0;
  int errors = 0;

  scheduler_request_responder_if #(.WORD_W(WORD_W)) mem_if ();

  scheduler_request_responder #(
    .WORD_W  (WORD_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .ramREN_curr  (ramREN_curr),
    .ramWEN_curr  (ramWEN_curr),
    .ramaddr_rq   (ramaddr_rq),
    .ramstore_rq  (ramstore_rq),
    .request_done (request_done),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .resp_addr    (resp_addr),
    .resp_err     (resp_err),
    .mem          (mem_if.master),
    .busy         (busy),
    .done_count   (done_count)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    ramREN_curr = 1'b0; ramWEN_curr = 1'b0;
    ramaddr_rq = '0; ramstore_rq = '0;
    mem_if.mem_ready = 1'b0; mem_if.mem_rdata = '0;
    #12;
    checks++; if ({request_done, load_valid, resp_err, busy, mem_if.mem_ren, mem_if.mem_wen} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b expected 000000", {request_done, load_valid, resp_err, busy, mem_if.mem_ren, mem_if.mem_wen}); end
    checks++; if (done_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", done_count); end
    checks++; if (load_data !== 32'd0) begin errors++; $display("FAIL reset_load_data: got %h expected 0", load_data); end
    @(negedge CLK); nRST = 1'b1;
    tick();
    $display("reset: done_count=%0d busy=%b", done_count, busy);
  endtask

  task automatic test_read_immediate();
    ramREN_curr = 1'b1; ramaddr_rq = 32'h0000_1000;
    mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'hDEAD_BEEF;
    tick();
    ramREN_curr = 1'b0;
    checks++; if (mem_if.mem_ren !== 1'b1 || mem_if.mem_addr !== 32'h1000) begin errors++; $display("FAIL rd_access: got ren=%b addr=%h expected ren=1 addr=00001000", mem_if.mem_ren, mem_if.mem_addr); end
    checks++; if (request_done !== 1'b0) begin errors++; $display("FAIL rd_early_done: got %b expected 0", request_done); end
    tick();
    checks++; if ({request_done, load_valid, resp_err, mem_if.mem_ren} !== 4'b1100) begin errors++; $display("FAIL rd_done_flags: got %b expected 1100", {request_done, load_valid, resp_err, mem_if.mem_ren}); end
    checks++; if (load_data !== 32'hDEAD_BEEF || resp_addr !== 32'h1000) begin errors++; $display("FAIL rd_data: got data=%h addr=%h expected deadbeef 00001000", load_data, resp_addr); end
    mem_if.mem_ready = 1'b0;
    tick();
    checks++; if (done_count !== 16'd1 || request_done !== 1'b0 || load_valid !== 1'b0) begin errors++; $display("FAIL rd_gap: got cnt=%0d done=%b lv=%b expected 1 0 0", done_count, request_done, load_valid); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_idle: got busy=%b expected 0", busy); end
    $display("read immediate: data=%h addr=%h done_count=%0d", load_data, resp_addr, done_count);
  endtask

  task automatic test_write_wait();
    int wen_cycles = 0;
    ramWEN_curr = 1'b1; ramaddr_rq = 32'h2000; ramstore_rq = 32'hCAFE_F00D;
    mem_if.mem_ready = 1'b0;
    tick();
    ramWEN_curr = 1'b0; ramstore_rq = '0;
    for (int i = 0; i < 6; i++) begin
      if (mem_if.mem_wen === 1'b1 && mem_if.mem_wdata === 32'hCAFE_F00D && mem_if.mem_addr === 32'h2000) wen_cycles++;
      if (i == 5) mem_if.mem_ready = 1'b1;
      tick();
    end
    mem_if.mem_ready = 1'b0;
    checks++; if (wen_cycles !== 6) begin errors++; $display("FAIL wr_strobe_cycles: got %0d expected 6", wen_cycles); end
    checks++; if ({request_done, load_valid, resp_err, mem_if.mem_wen} !== 4'b1000) begin errors++; $display("FAIL wr_done_flags: got %b expected 1000", {request_done, load_valid, resp_err, mem_if.mem_wen}); end
    checks++; if (load_data !== 32'hDEAD_BEEF || resp_addr !== 32'h2000) begin errors++; $display("FAIL wr_resp: got data=%h addr=%h expected deadbeef 00002000", load_data, resp_addr); end
    tick(); tick();
    checks++; if (done_count !== 16'd2) begin errors++; $display("FAIL wr_count: got %0d expected 2", done_count); end
    $display("write wait: wen_cycles=%0d done_count=%0d", wen_cycles, done_count);
  endtask

  task automatic test_timeout();
    int n = 0;
    ramREN_curr = 1'b1; ramaddr_rq = 32'h4000;
    mem_if.mem_ready = 1'b0;
    tick();
    ramREN_curr = 1'b0;
    while (mem_if.mem_ren === 1'b1 && n < 400) begin
      n++;
      tick();
    end
    checks++; if (n !== TIMEOUT) begin errors++; $display("FAIL tmo_cycles: got %0d expected %0d", n, TIMEOUT); end
    checks++; if ({request_done, resp_err, load_valid} !== 3'b110) begin errors++; $display("FAIL tmo_flags: got %b expected 110", {request_done, resp_err, load_valid}); end
    checks++; if (resp_addr !== 32'h4000) begin errors++; $display("FAIL tmo_addr: got %h expected 00004000", resp_addr); end
    tick(); tick();
    checks++; if (done_count !== 16'd3 || busy !== 1'b0) begin errors++; $display("FAIL tmo_count: got cnt=%0d busy=%b expected 3 0", done_count, busy); end
    $display("timeout: ren_cycles=%0d done_count=%0d", n, done_count);
  endtask

  task automatic test_ready_at_limit();
    ramREN_curr = 1'b1; ramaddr_rq = 32'h4400;
    mem_if.mem_ready = 1'b0; mem_if.mem_rdata = 32'h1234_5678;
    tick();
    ramREN_curr = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    checks++; if (mem_if.mem_ren !== 1'b1 || request_done !== 1'b0) begin errors++; $display("FAIL limit_still_access: got ren=%b done=%b expected 1 0", mem_if.mem_ren, request_done); end
    mem_if.mem_ready = 1'b1;
    tick();
    mem_if.mem_ready = 1'b0;
    checks++; if ({request_done, load_valid, resp_err} !== 3'b110 || load_data !== 32'h1234_5678) begin errors++; $display("FAIL limit_success: got flags=%b data=%h expected 110 12345678", {request_done, load_valid, resp_err}, load_data); end
    tick(); tick();
    $display("ready at limit: data=%h done_count=%0d", load_data, done_count);
  endtask

  task automatic test_illegal();
    ramREN_curr = 1'b1; ramWEN_curr = 1'b1; ramaddr_rq = 32'h3000;
    mem_if.mem_ready = 1'b1;
    tick();
    ramREN_curr = 1'b0; ramWEN_curr = 1'b0;
    checks++; if ({mem_if.mem_ren, mem_if.mem_wen} !== 2'b00) begin errors++; $display("FAIL ill_strobe: got %b expected 00", {mem_if.mem_ren, mem_if.mem_wen}); end
    checks++; if ({request_done, resp_err, load_valid} !== 3'b110 || resp_addr !== 32'h3000) begin errors++; $display("FAIL ill_resp: got flags=%b addr=%h expected 110 00003000", {request_done, resp_err, load_valid}, resp_addr); end
    mem_if.mem_ready = 1'b0;
    tick();
    checks++; if (resp_err !== 1'b0 || done_count !== 16'd5) begin errors++; $display("FAIL ill_gap: got err=%b cnt=%0d expected 0 5", resp_err, done_count); end
    tick();
    $display("illegal: addr=%h done_count=%0d", resp_addr, done_count);
  endtask

  task automatic test_reset_mid_access();
    ramREN_curr = 1'b1; ramaddr_rq = 32'h5000;
    mem_if.mem_ready = 1'b0;
    tick();
    ramREN_curr = 1'b0;
    tick(); tick();
    #2 nRST = 1'b0;
    #1;
    checks++; if ({mem_if.mem_ren, busy, request_done} !== 3'b000) begin errors++; $display("FAIL rst_async: got ren/busy/done=%b expected 000", {mem_if.mem_ren, busy, request_done}); end
    checks++; if (done_count !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", done_count); end
    tick(); tick();
    @(negedge CLK); nRST = 1'b1;
    tick(); tick();
    checks++; if ({busy, request_done, mem_if.mem_ren} !== 3'b000 || done_count !== 16'd0) begin errors++; $display("FAIL rst_release: got flags=%b cnt=%0d expected 000 0", {busy, request_done, mem_if.mem_ren}, done_count); end
    $display("reset mid access: busy=%b done_count=%0d", busy, done_count);
  endtask

  task automatic test_back_to_back();
    logic [WORD_W-1:0] q_addr [3];
    logic              q_read [3];
    int                done_cyc [3];
    int                h = 0;
    int                cyc = 0;
    q_addr[0] = 32'h10; q_read[0] = 1'b1;
    q_addr[1] = 32'h14; q_read[1] = 1'b0;
    q_addr[2] = 32'h18; q_read[2] = 1'b1;
    mem_if.mem_ready = 1'b1;
    mem_if.mem_rdata = 32'hA500_0000;
    ramREN_curr = q_read[0]; ramWEN_curr = !q_read[0];
    ramaddr_rq = q_addr[0]; ramstore_rq = 32'h5A00_0000;
    while (h < 3 && cyc < 40) begin
      tick();
      cyc++;
      mem_if.mem_rdata = 32'hA500_0000 | mem_if.mem_addr;
      if (request_done === 1'b1) begin
        done_cyc[h] = cyc;
        checks++; if (resp_addr !== q_addr[h] || load_valid !== q_read[h] || resp_err !== 1'b0) begin errors++; $display("FAIL b2b_resp%0d: got addr=%h lv=%b err=%b expected %h %b 0", h, resp_addr, load_valid, resp_err, q_addr[h], q_read[h]); end
        if (q_read[h]) begin
          checks++; if (load_data !== (32'hA500_0000 | q_addr[h])) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", h, load_data, 32'hA500_0000 | q_addr[h]); end
        end
        $display("back-to-back: retired #%0d addr=%h at cycle %0d", h, resp_addr, cyc);
        h++;
        if (h < 3) begin
          ramREN_curr = q_read[h]; ramWEN_curr = !q_read[h]; ramaddr_rq = q_addr[h];
        end else begin
          ramREN_curr = 1'b0; ramWEN_curr = 1'b0;
        end
      end
    end
    checks++; if (h !== 3) begin errors++; $display("FAIL b2b_retired: got %0d expected 3 within cycle budget", h); end
    if (h == 3) begin
      checks++; if (done_cyc[1] - done_cyc[0] !== 4 || done_cyc[2] - done_cyc[1] !== 4) begin errors++; $display("FAIL b2b_spacing: got %0d,%0d expected 4,4", done_cyc[1] - done_cyc[0], done_cyc[2] - done_cyc[1]); end
    end
    mem_if.mem_ready = 1'b0;
    tick(); tick();
    checks++; if (done_count !== 16'd3 || busy !== 1'b0) begin errors++; $display("FAIL b2b_count: got cnt=%0d busy=%b expected 3 0", done_count, busy); end
  endtask

  initial begin
    test_reset();
    test_read_immediate();
    test_write_wait();
    test_timeout();
    test_ready_at_limit();
    test_illegal();
    test_reset_mid_access();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
